mem_responder: RTL and testbench

Memory-side responder for the processor's MFA/MFC memory handshake. It accepts a request from the data path (activate, read/write, size, address, write data) and performs a byte, halfword or word access on a big-endian byte-addressed RAM after a programmable number of wait states. It then holds MFC until the requester drops MFA. It replaces the zero-wait RAM inside the data path, so the control unit's wait-for-MFC states are exercised with real latency.

---
 rtl/mem_pkg.sv | 28 ++
 rtl/mem_responder_if.sv | 24 ++
 rtl/mem_byte_array.sv | 35 +++
 rtl/mem_responder.sv | 176 +++++++++++++++++
 tb/tb_mem_responder.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared constants for the MFA/MFC memory handshake: access size codes,
// read/write codes, responder FSM encoding and the alignment rule.
package mem_pkg;

  localparam logic [1:0] BYTE = 2'b00;
  localparam logic [1:0] HALF = 2'b01;
  localparam logic [1:0] WORD = 2'b10;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mem_state_t;

  // Illegal size codes and misaligned halfword/word accesses are rejected.
  function automatic logic access_bad(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      BYTE:    return 1'b0;
      HALF:    return lane[0];
      WORD:    return lane != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// MFA/MFC request/response bundle between a requester (master) and the
// memory responder (slave).
interface mem_responder_if #(
  parameter int ADDR_W = 8
);
  logic              MFA;
  logic              RW;
  logic [1:0]        SIZE;
  logic [ADDR_W-1:0] ADDR;
  logic [31:0]       DATA_IN;
  logic [31:0]       DATA_OUT;
  logic              MFC;
  logic              ERR;

  modport master (
    output MFA, RW, SIZE, ADDR, DATA_IN,
    input  DATA_OUT, MFC, ERR
  );

  modport slave (
    input  MFA, RW, SIZE, ADDR, DATA_IN,
    output DATA_OUT, MFC, ERR
  );
endinterface

// File: rtl/mem_byte_array.sv
// Byte-addressed storage organised as big-endian 32-bit words: four byte-lane
// write enables and a registered word read port. Contents survive reset.
module mem_byte_array #(
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [ADDR_W-3:0] word_addr,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  input  logic              rd_en,
  output logic [31:0]       rd_word
);

  logic [7:0] Mem [0:(2**ADDR_W)-1];

  // Lane 3 (bits 31:24) maps to byte offset 0 within the word.
  always_ff @(posedge CLK) begin
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) begin
        Mem[{word_addr, 2'(3 - i)}] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      rd_word <= '0;
    end else if (rd_en) begin
      rd_word <= {Mem[{word_addr, 2'd0}], Mem[{word_addr, 2'd1}],
                  Mem[{word_addr, 2'd2}], Mem[{word_addr, 2'd3}]};
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side MFA/MFC responder: captures a request, waits WAIT_CYCLES,
// performs a byte/halfword/word access and holds MFC until MFA drops.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input logic             CLK,
  input logic             Reset,
  mem_responder_if.slave  bus
);

  localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

  mem_state_t        state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic              capture, count_down, do_access, release_rsp;

  logic              req_rw;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_data;
  logic              req_bad;

  logic              mfc_q, err_q;
  logic [1:0]        out_size;
  logic [1:0]        out_lane;
  logic              out_zero;

  logic [3:0]        lane_be;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic              rd_en;
  logic [31:0]       rd_word;
  logic [31:0]       dout;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    capture     = 1'b0;
    count_down  = 1'b0;
    do_access   = 1'b0;
    release_rsp = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.MFA) begin
          capture    = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (!bus.MFA) begin
          state_next = IDLE;
        end else if (cnt != '0) begin
          count_down = 1'b1;
        end else begin
          do_access  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (!bus.MFA) begin
          release_rsp = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      cnt      <= '0;
      req_rw   <= READ;
      req_size <= BYTE;
      req_addr <= '0;
      req_data <= '0;
    end else if (capture) begin
      cnt      <= CNT_W'(WAIT_CYCLES);
      req_rw   <= bus.RW;
      req_size <= bus.SIZE;
      req_addr <= bus.ADDR;
      req_data <= bus.DATA_IN;
    end else if (count_down) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign req_bad = access_bad(req_size, req_addr[1:0]);

  always_comb begin
    lane_be = '0;
    wdata   = req_data;
    case (req_size)
      BYTE: begin
        lane_be = 4'b1000 >> req_addr[1:0];
        wdata   = {4{req_data[7:0]}};
      end
      HALF: begin
        lane_be = req_addr[1] ? 4'b0011 : 4'b1100;
        wdata   = {2{req_data[15:0]}};
      end
      WORD:    lane_be = 4'b1111;
      default: lane_be = '0;
    endcase
  end

  assign be    = (do_access && req_rw == WRITE && !req_bad) ? lane_be : '0;
  assign rd_en = do_access && req_rw == READ && !req_bad;

  mem_byte_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .CLK       (CLK),
    .Reset     (Reset),
    .word_addr (req_addr[ADDR_W-1:2]),
    .be        (be),
    .wdata     (wdata),
    .rd_en     (rd_en),
    .rd_word   (rd_word)
  );

  // The read port returns the whole word; the steering below selects and
  // zero-extends the requested lanes from registered response state, so
  // DATA_OUT stays a pure function of flops and holds until the next read.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      mfc_q    <= 1'b0;
      err_q    <= 1'b0;
      out_size <= BYTE;
      out_lane <= '0;
      out_zero <= 1'b1;
    end else if (do_access) begin
      mfc_q <= 1'b1;
      err_q <= req_bad;
      if (req_bad) begin
        out_zero <= 1'b1;
      end else if (req_rw == READ) begin
        out_zero <= 1'b0;
        out_size <= req_size;
        out_lane <= req_addr[1:0];
      end
    end else if (release_rsp) begin
      mfc_q <= 1'b0;
      err_q <= 1'b0;
    end
  end

  always_comb begin
    dout = '0;
    if (!out_zero) begin
      case (out_size)
        BYTE: begin
          case (out_lane)
            2'd0:    dout = {24'd0, rd_word[31:24]};
            2'd1:    dout = {24'd0, rd_word[23:16]};
            2'd2:    dout = {24'd0, rd_word[15:8]};
            default: dout = {24'd0, rd_word[7:0]};
          endcase
        end
        HALF:    dout = {16'd0, out_lane[1] ? rd_word[15:0] : rd_word[31:16]};
        default: dout = rd_word;
      endcase
    end
  end

  assign bus.DATA_OUT = dout;
  assign bus.MFC      = mfc_q;
  assign bus.ERR      = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder: a WAIT_CYCLES=2 and a WAIT_CYCLES=0
// instance checked against a byte-array reference model.
module tb_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic        mfa;
  logic        rw;
  logic [1:0]  size;
  logic [7:0]  addr;
  logic [31:0] din;

  int total = 0;
  int bad   = 0;

  logic [7:0] model_mem [0:1][0:255];

  mem_responder_if #(.ADDR_W(8)) bus_a ();
  mem_responder_if #(.ADDR_W(8)) bus_b ();

  assign bus_a.MFA     = mfa & ~sel;
  assign bus_a.RW      = rw;
  assign bus_a.SIZE    = size;
  assign bus_a.ADDR    = addr;
  assign bus_a.DATA_IN = din;
  assign bus_b.MFA     = mfa & sel;
  assign bus_b.RW      = rw;
  assign bus_b.SIZE    = size;
  assign bus_b.ADDR    = addr;
  assign bus_b.DATA_IN = din;

  mem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut_a (
    .CLK   (clk),
    .Reset (rst_n),
    .bus   (bus_a)
  );

  mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut_b (
    .CLK   (clk),
    .Reset (rst_n),
    .bus   (bus_b)
  );

  logic        obs_mfc;
  logic        obs_err;
  logic [31:0] obs_dout;
  assign obs_mfc  = sel ? bus_b.MFC      : bus_a.MFC;
  assign obs_err  = sel ? bus_b.ERR      : bus_a.ERR;
  assign obs_dout = sel ? bus_b.DATA_OUT : bus_a.DATA_OUT;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic model_bad(input logic [1:0] sz, input logic [7:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic logic [31:0] model_read(input bit s, input logic [1:0] sz, input logic [7:0] a);
    int ai = int'(a);
    case (sz)
      2'd0:    return {24'd0, model_mem[s][ai]};
      2'd1:    return {16'd0, model_mem[s][ai], model_mem[s][ai+1]};
      default: return {model_mem[s][ai], model_mem[s][ai+1], model_mem[s][ai+2], model_mem[s][ai+3]};
    endcase
  endfunction

  task automatic model_write(input bit s, input logic [1:0] sz, input logic [7:0] a, input logic [31:0] d);
    int ai = int'(a);
    case (sz)
      2'd0: model_mem[s][ai] = d[7:0];
      2'd1: begin
        model_mem[s][ai]   = d[15:8];
        model_mem[s][ai+1] = d[7:0];
      end
      default: begin
        model_mem[s][ai]   = d[31:24];
        model_mem[s][ai+1] = d[23:16];
        model_mem[s][ai+2] = d[15:8];
        model_mem[s][ai+3] = d[7:0];
      end
    endcase
  endtask

  task automatic scramble();
    rw   = 1'($urandom);
    size = 2'($urandom);
    addr = 8'($urandom);
    din  = $urandom;
  endtask

  // Called at a negedge; returns at the negedge where MFC=0 is seen again.
  task automatic access(input bit s, input logic rw_i, input logic [1:0] sz,
                        input logic [7:0] a, input logic [31:0] d,
                        input int hold, output logic [31:0] rdat);
    int          lat_exp = s ? 2 : 4;
    int          n = 0;
    logic        exp_err = model_bad(sz, a);
    logic [31:0] exp_d   = 32'd0;
    logic        chk_d   = exp_err || (rw_i == 1'b0);
    if (!exp_err && rw_i == 1'b0) exp_d = model_read(s, sz, a);
    if (!exp_err && rw_i == 1'b1) model_write(s, sz, a, d);
    sel  = s;
    rw   = rw_i;
    size = sz;
    addr = a;
    din  = d;
    mfa  = 1'b1;
    do begin
      @(negedge clk);
      n++;
      scramble();
    end while (!obs_mfc && n < 20);
    check_eq("latency", 32'(n), 32'(lat_exp));
    check_eq("err", {31'd0, obs_err}, {31'd0, exp_err});
    if (chk_d) check_eq("data", obs_dout, exp_d);
    rdat = obs_dout;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      scramble();
      check_eq("hold_mfc", {31'd0, obs_mfc}, 32'd1);
      if (chk_d) check_eq("hold_data", obs_dout, exp_d);
    end
    mfa = 1'b0;
    @(negedge clk);
    check_eq("release_mfc", {31'd0, obs_mfc}, 32'd0);
    check_eq("release_err", {31'd0, obs_err}, 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    logic        seen;
    bit          s;
    logic [1:0]  sz;
    logic [7:0]  a;

    rst_n = 1'b0;
    sel   = 1'b0;
    mfa   = 1'b0;
    rw    = 1'b0;
    size  = 2'd0;
    addr  = 8'd0;
    din   = 32'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_mfc_a", {31'd0, bus_a.MFC}, 32'd0);
    check_eq("rst_err_a", {31'd0, bus_a.ERR}, 32'd0);
    check_eq("rst_dout_a", bus_a.DATA_OUT, 32'd0);
    check_eq("rst_mfc_b", {31'd0, bus_b.MFC}, 32'd0);
    check_eq("rst_dout_b", bus_b.DATA_OUT, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fill both memories so the model starts from known contents.
    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < 64; w++) begin
        access(k[0], 1'b1, 2'd2, 8'(w * 4), $urandom, 0, r);
      end
    end

    access(1'b0, 1'b1, 2'd2, 8'h00, 32'h12345678, 0, r);
    access(1'b0, 1'b0, 2'd2, 8'h00, 32'd0, 0, r);
    check_eq("dir_word0", r, 32'h12345678);
    access(1'b0, 1'b1, 2'd0, 8'h01, 32'hFFFFFFAB, 0, r);
    access(1'b0, 1'b0, 2'd2, 8'h00, 32'd0, 0, r);
    check_eq("dir_byte_wr", r, 32'h12AB5678);
    access(1'b0, 1'b0, 2'd1, 8'h02, 32'd0, 0, r);
    check_eq("dir_half_rd", r, 32'h00005678);
    access(1'b0, 1'b1, 2'd2, 8'hFC, 32'hDEADBEEF, 0, r);
    access(1'b0, 1'b0, 2'd0, 8'hFF, 32'd0, 0, r);
    check_eq("dir_top_byte", r, 32'h000000EF);
    access(1'b0, 1'b1, 2'd2, 8'h02, 32'hCAFEF00D, 0, r);
    check_eq("dir_misalign_dout", r, 32'd0);
    access(1'b0, 1'b0, 2'd2, 8'h00, 32'd0, 0, r);
    check_eq("dir_misalign_keep", r, 32'h12AB5678);

    // Abort: MFA drops while the write is still waiting.
    sel = 1'b0; rw = 1'b1; size = 2'd2; addr = 8'h10; din = 32'h0BADF00D; mfa = 1'b1;
    @(negedge clk);
    mfa  = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | obs_mfc;
    end
    check_eq("abort_no_mfc", {31'd0, seen}, 32'd0);
    access(1'b0, 1'b0, 2'd2, 8'h10, 32'd0, 0, r);

    // Asynchronous reset while a write is in flight.
    sel = 1'b0; rw = 1'b1; size = 2'd2; addr = 8'h20; din = 32'hA5A5A5A5; mfa = 1'b1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_mfc", {31'd0, bus_a.MFC}, 32'd0);
    check_eq("midrst_err", {31'd0, bus_a.ERR}, 32'd0);
    check_eq("midrst_dout", bus_a.DATA_OUT, 32'd0);
    mfa = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    access(1'b0, 1'b0, 2'd2, 8'h20, 32'd0, 0, r);

    // Zero-wait instance: back-to-back reads, then accesses held in DONE.
    access(1'b1, 1'b0, 2'd2, 8'h00, 32'd0, 0, r);
    access(1'b1, 1'b0, 2'd2, 8'h04, 32'd0, 0, r);
    access(1'b1, 1'b0, 2'd2, 8'h08, 32'd0, 4, r);
    access(1'b1, 1'b1, 2'd0, 8'h05, 32'h0000003C, 3, r);
    access(1'b1, 1'b0, 2'd2, 8'h04, 32'd0, 0, r);

    for (int t = 0; t < 200; t++) begin
      s  = 1'($urandom);
      sz = 2'($urandom_range(0, 3));
      a  = 8'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      access(s, 1'($urandom), sz, a, $urandom, $urandom_range(0, 2), r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
